// File: rtl/multiprecision_add_sequencer.sv
// ============================================================================
// Module   : multiprecision_add_sequencer (+ multiprecision_add_sequencer_cla)
// Brief    : W = N*K bit add/subtract, one N-bit chunk per cycle, LSB first.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multiprecision_add_sequencer_cla #(
  parameter int N = 32
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_ci,
  output logic [N-1:0] o_sum,
  output logic         o_co
);

  localparam int c_LVL = (N > 1) ? $clog2(N) : 0;

  logic [N-1:0]            w_p;
  logic [c_LVL:0][N-1:0]   w_gg;
  logic [c_LVL:0][N-1:0]   w_pp;
  logic                    w_unused_pp;

  assign w_p         = i_a ^ i_b;
  assign w_pp[0]     = w_p;
  assign w_unused_pp = ^w_pp;

  // Carry-in is folded into bit 0's generate, so w_gg[c_LVL][i] is the carry into bit i+1.
  for (genvar i = 0; i < N; i++) begin : g_gen0
    if (i == 0) begin : g_lsb
      assign w_gg[0][i] = (i_a[i] & i_b[i]) | (w_p[i] & i_ci);
    end else begin : g_other
      assign w_gg[0][i] = i_a[i] & i_b[i];
    end
  end

  for (genvar l = 0; l < c_LVL; l++) begin : g_level
    for (genvar i = 0; i < N; i++) begin : g_node
      if (i >= (1 << l)) begin : g_merge
        assign w_gg[l+1][i] = w_gg[l][i] | (w_pp[l][i] & w_gg[l][i-(1<<l)]);
        assign w_pp[l+1][i] = w_pp[l][i] & w_pp[l][i-(1<<l)];
      end else begin : g_pass
        assign w_gg[l+1][i] = w_gg[l][i];
        assign w_pp[l+1][i] = w_pp[l][i];
      end
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_sum
    if (i == 0) begin : g_lsb
      assign o_sum[i] = w_p[i] ^ i_ci;
    end else begin : g_other
      assign o_sum[i] = w_p[i] ^ w_gg[c_LVL][i-1];
    end
  end

  assign o_co = w_gg[c_LVL][N-1];

endmodule

module multiprecision_add_sequencer #(
  parameter int N = 32,
  parameter int K = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_in_valid,
  output logic           o_in_ready,
  input  logic [N*K-1:0] i_in_a,
  input  logic [N*K-1:0] i_in_b,
  input  logic           i_in_ci,
  input  logic           i_in_sub,
  output logic           o_out_valid,
  input  logic           i_out_ready,
  output logic [N*K-1:0] o_out_c,
  output logic           o_out_co,
  output logic           o_busy
);

  localparam int W    = N * K;
  localparam int IDXW = (K > 1) ? $clog2(K) : 1;

  localparam logic [IDXW-1:0] c_LAST_IDX = IDXW'(K - 1);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_RUN  = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  logic [1:0]            r_state;
  logic [K-1:0][N-1:0]   r_a;
  logic [K-1:0][N-1:0]   r_b;
  logic [K-1:0][N-1:0]   r_c;
  logic                  r_sub;
  logic                  r_carry;
  logic                  r_co;
  logic [IDXW-1:0]       r_idx;

  logic [N-1:0]          w_sum;
  logic                  w_cout;

  multiprecision_add_sequencer_cla #(
    .N (N)
  ) u_cla (
    .i_a   (r_a[r_idx]),
    .i_b   (r_b[r_idx]),
    .i_ci  (r_carry),
    .o_sum (w_sum),
    .o_co  (w_cout)
  );

  // Subtract is A + ~B + ~borrow_in; the final carry is inverted back into a borrow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= '0;
      r_sub   <= 1'b0;
      r_carry <= 1'b0;
      r_co    <= 1'b0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (i_in_valid) begin
            r_a     <= i_in_a;
            r_b     <= i_in_sub ? ~i_in_b : i_in_b;
            r_sub   <= i_in_sub;
            r_carry <= i_in_sub ^ i_in_ci;
            r_idx   <= '0;
            r_state <= c_RUN;
          end
        end
        c_RUN: begin
          r_c[r_idx] <= w_sum;
          r_carry    <= w_cout;
          r_idx      <= r_idx + 1'b1;
          if (r_idx == c_LAST_IDX) begin
            r_co    <= r_sub ^ w_cout;
            r_state <= c_DONE;
          end
        end
        c_DONE: begin
          if (i_out_ready) begin
            r_state <= c_IDLE;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign o_in_ready  = (r_state == c_IDLE);
  assign o_out_valid = (r_state == c_DONE);
  assign o_busy      = (r_state != c_IDLE);
  assign o_out_c     = W'(r_c);
  assign o_out_co    = r_co;

endmodule

`default_nettype wire

// File: tb/tb_multiprecision_add_sequencer.sv
// ============================================================================
// Module   : tb_multiprecision_add_sequencer
// Brief    : Scoreboard bench for three configurations (8x4, 8x1, 32x4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multiprecision_add_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        a_iv, a_ir, a_ci, a_sub, a_ov, a_ordy, a_co, a_busy;
  logic [31:0] a_a, a_b, a_c;
  logic        b_iv, b_ir, b_ci, b_sub, b_ov, b_ordy, b_co, b_busy;
  logic [7:0]  b_a, b_b, b_c;
  logic        c_iv, c_ir, c_ci, c_sub, c_ov, c_ordy, c_co, c_busy;
  logic [127:0] c_a, c_b, c_c;

  multiprecision_add_sequencer #(.N(8), .K(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .i_in_valid(a_iv), .o_in_ready(a_ir),
    .i_in_a(a_a), .i_in_b(a_b), .i_in_ci(a_ci), .i_in_sub(a_sub),
    .o_out_valid(a_ov), .i_out_ready(a_ordy), .o_out_c(a_c), .o_out_co(a_co),
    .o_busy(a_busy));

  multiprecision_add_sequencer #(.N(8), .K(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .i_in_valid(b_iv), .o_in_ready(b_ir),
    .i_in_a(b_a), .i_in_b(b_b), .i_in_ci(b_ci), .i_in_sub(b_sub),
    .o_out_valid(b_ov), .i_out_ready(b_ordy), .o_out_c(b_c), .o_out_co(b_co),
    .o_busy(b_busy));

  multiprecision_add_sequencer #(.N(32), .K(4)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .i_in_valid(c_iv), .o_in_ready(c_ir),
    .i_in_a(c_a), .i_in_b(c_b), .i_in_ci(c_ci), .i_in_sub(c_sub),
    .o_out_valid(c_ov), .i_out_ready(c_ordy), .o_out_c(c_c), .o_out_co(c_co),
    .o_busy(c_busy));

  int total = 0;
  int bad   = 0;
  int acc_c = 0;
  int comp_c = 0;
  logic [32:0]  qa[$];
  logic [32:0]  qb[$];
  logic [128:0] qc[$];

  task automatic chk(input string nm, input logic [128:0] act, input logic [128:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Monitors: pop and compare on every completed output handshake.
  always @(negedge clk) begin
    if (rst_n && a_ov && a_ordy) begin
      if (qa.size() == 0) begin
        total++; bad++;
        $display("FAIL a_unexpected: got %h want none", {a_co, a_c});
      end else chk("a_result", {a_co, a_c}, qa.pop_front());
    end
    if (rst_n && b_ov && b_ordy) begin
      if (qb.size() == 0) begin
        total++; bad++;
        $display("FAIL b_unexpected: got %h want none", {b_co, b_c});
      end else chk("b_result", {b_co, b_c}, qb.pop_front());
    end
    if (rst_n && c_ov && c_ordy) begin
      comp_c++;
      if (qc.size() == 0) begin
        total++; bad++;
        $display("FAIL c_unexpected: got %h want none", {c_co, c_c});
      end else chk("c_result", {c_co, c_c}, qc.pop_front());
    end
  end

  always @(posedge clk) begin
    #1;
    c_ordy = ($urandom_range(0, 3) != 0);
  end

  function automatic logic ir_of(input int w);
    return (w == 0) ? a_ir : b_ir;
  endfunction

  function automatic logic ov_of(input int w);
    return (w == 0) ? a_ov : b_ov;
  endfunction

  function automatic logic busy_of(input int w);
    return (w == 0) ? a_busy : b_busy;
  endfunction

  // Called at a falling edge; returns at the falling edge where out_valid is first seen.
  task automatic send(input int w, input logic [31:0] a, input logic [31:0] b,
                      input logic ci, input logic sub, input logic [31:0] ec,
                      input logic eco, input int lat);
    int g;
    int cnt;
    if (w == 0) qa.push_back({eco, ec});
    else        qb.push_back({24'b0, eco, ec[7:0]});
    g = 0;
    while (!ir_of(w) && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk("in_ready_before_accept", ir_of(w), 1);
    if (w == 0) begin
      a_iv = 1'b1; a_a = a; a_b = b; a_ci = ci; a_sub = sub;
    end else begin
      b_iv = 1'b1; b_a = a[7:0]; b_b = b[7:0]; b_ci = ci; b_sub = sub;
    end
    @(posedge clk);
    #1;
    a_iv = 1'b0; b_iv = 1'b0;
    a_a = $urandom; a_b = $urandom; b_a = 8'($urandom); b_b = 8'($urandom);
    a_ci = ~a_ci; b_ci = ~b_ci;
    cnt = 0;
    do begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
      if (cnt == 1) begin
        chk("in_ready_low_busy", {ir_of(w), busy_of(w)}, 2'b01);
      end
    end while (!ov_of(w) && cnt < 20);
    chk("latency", cnt, lat);
  endtask

  task automatic run_random();
    logic [127:0] ra, rb;
    logic         rci, rsub;
    logic [128:0] m;
    int g;
    for (int n = 0; n < 1000; n++) begin
      ra = {$urandom, $urandom, $urandom, $urandom};
      rb = {$urandom, $urandom, $urandom, $urandom};
      if (n % 16 == 3) rb = ra;
      if (n % 16 == 7) ra = '1;
      if (n % 16 == 11) rb = '0;
      rci  = 1'($urandom_range(0, 1));
      rsub = 1'($urandom_range(0, 1));
      g = 0;
      while (!c_ir && g < 100) begin
        c_a = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        g++;
      end
      if (!c_ir) begin
        total++; bad++;
        $display("FAIL c_ready_timeout: got 0 want 1");
        break;
      end
      c_iv = 1'b1; c_a = ra; c_b = rb; c_ci = rci; c_sub = rsub;
      if (rsub) m = {1'b0, ra} - {1'b0, rb} - 129'(rci);
      else      m = {1'b0, ra} + {1'b0, rb} + 129'(rci);
      qc.push_back(m);
      acc_c++;
      @(posedge clk);
      #1;
      c_a = ~ra; c_b = ~rb; c_sub = ~rsub;
      @(negedge clk);
    end
    c_iv = 1'b0;
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    a_iv = 0; a_a = 0; a_b = 0; a_ci = 0; a_sub = 0; a_ordy = 1;
    b_iv = 0; b_a = 0; b_b = 0; b_ci = 0; b_sub = 0; b_ordy = 1;
    c_iv = 0; c_a = 0; c_b = 0; c_ci = 0; c_sub = 0;
    rst_n = 1'b0;
    #1;
    chk("reset_state", {a_ir, a_ov, a_busy, a_co, a_c}, {1'b1, 1'b0, 1'b0, 1'b0, 32'h0});
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    send(0, 32'hFFFFFFFF, 32'h00000001, 0, 0, 32'h00000000, 1, 4);
    send(0, 32'h00000000, 32'h00000001, 0, 1, 32'hFFFFFFFF, 1, 4);
    send(0, 32'h12345678, 32'h02345678, 1, 1, 32'h0FFFFFFF, 0, 4);
    send(0, 32'h80000000, 32'h80000000, 1, 0, 32'h00000001, 1, 4);
    send(0, 32'h00000005, 32'h00000005, 0, 1, 32'h00000000, 0, 4);

    // Backpressure: result held, new requests ignored while out_ready is low.
    @(posedge clk); #1; a_ordy = 1'b0;
    @(negedge clk);
    send(0, 32'h000000FF, 32'h00000001, 0, 0, 32'h00000100, 0, 4);
    for (int i = 0; i < 5; i++) begin
      a_iv = 1'b1; a_a = $urandom; a_b = $urandom; a_sub = 1'($urandom);
      @(posedge clk);
      @(negedge clk);
      chk("stall_hold", {a_ov, a_ir, a_co, a_c}, {1'b1, 1'b0, 1'b0, 32'h00000100});
    end
    @(posedge clk); #1; a_iv = 1'b0; a_ordy = 1'b1;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("idle_after_release", {a_ir, a_ov}, 2'b10);
    send(0, 32'h00000010, 32'h00000020, 1, 0, 32'h00000031, 0, 4);

    // Reset in the middle of a run.
    g = 0;
    while (!a_ir && g < 20) begin @(negedge clk); g++; end
    a_iv = 1'b1; a_a = 32'h11111111; a_b = 32'h22222222; a_ci = 0; a_sub = 0;
    @(posedge clk); #1; a_iv = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    chk("partial_chunks", a_c[15:0], 16'h3333);
    rst_n = 1'b0;
    #1;
    chk("async_reset", {a_ir, a_ov, a_busy, a_co, a_c}, {1'b1, 1'b0, 1'b0, 1'b0, 32'h0});
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(0, 32'h00000003, 32'h00000004, 0, 0, 32'h00000007, 0, 4);

    // Single-chunk configuration.
    g = 0;
    while (!b_ir && g < 20) begin @(negedge clk); g++; end
    send(1, 32'h80, 32'h80, 0, 0, 32'h00, 1, 1);
    send(1, 32'hFF, 32'h00, 1, 0, 32'h00, 1, 1);
    send(1, 32'h05, 32'h07, 0, 1, 32'hFE, 1, 1);
    send(1, 32'h07, 32'h05, 1, 1, 32'h01, 0, 1);

    repeat (4) @(negedge clk);
    run_random();

    g = 0;
    while ((qc.size() != 0 || qa.size() != 0 || qb.size() != 0) && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk("drain_queues", qa.size() + qb.size() + qc.size(), 0);
    chk("c_accepts_eq_completions", comp_c, acc_c);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
